// File: rtl/rx_frame_packer_if.sv
// ---------------------------------------------------------------------------
// rx_frame_packer_if
// Byte-wide receive stream from the MAC into the frame packer. The stream has
// no ready signal, so the sink must take every valid byte.
//   rx_axis_tdata  : frame byte
//   rx_axis_tvalid : byte valid
//   rx_axis_tlast  : last byte of the frame
//   rx_axis_tuser  : qualified by tlast, frame is bad (FCS/PHY error)
// master: stream source (MAC / testbench), slave: stream sink (packer)
// ---------------------------------------------------------------------------
interface rx_frame_packer_if;
    logic [7:0] rx_axis_tdata;
    logic       rx_axis_tvalid;
    logic       rx_axis_tlast;
    logic       rx_axis_tuser;

    modport master (
        output rx_axis_tdata,
        output rx_axis_tvalid,
        output rx_axis_tlast,
        output rx_axis_tuser
    );

    modport slave (
        input  rx_axis_tdata,
        input  rx_axis_tvalid,
        input  rx_axis_tlast,
        input  rx_axis_tuser
    );
endinterface

// File: rtl/rx_frame_packer.sv
// ---------------------------------------------------------------------------
// rx_frame_packer
// Packs received frames byte by byte into a 32-bit host buffer RAM starting
// at word 0, then posts the frame length to the host and holds the buffer
// until the host acknowledges it. Bad frames are written but not posted;
// frames that are oversize or arrive while the buffer is busy are dropped.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx           : byte stream sink (rx_frame_packer_if.slave)
//   ram_we       : buffer write strobe (one cycle per word)
//   ram_addr     : word address of the write
//   ram_wdata    : packed word, byte 0 of the word in bits [7:0]
//   ram_be       : byte enables of the write
//   frame_valid  : buffer holds a complete good frame
//   frame_len    : byte length of the held frame
//   frame_ack    : host releases the buffer
//   bad_count    : frames ended with tuser=1 (saturating)
//   drop_count   : frames dropped, busy buffer or oversize (saturating)
// ---------------------------------------------------------------------------
module rx_frame_packer #(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BYTES  = 1522
) (
    input  logic                    clk,
    input  logic                    rst,
    rx_frame_packer_if.slave        rx,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [31:0]             ram_wdata,
    output logic [3:0]              ram_be,
    output logic                    frame_valid,
    output logic [ADDR_WIDTH+2:0]   frame_len,
    input  logic                    frame_ack,
    output logic [15:0]             bad_count,
    output logic [15:0]             drop_count
);

    localparam int CW = ADDR_WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [31:0]            acc_q, acc_d;
    logic [3:0]             acc_be_q, acc_be_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [31:0]            ram_wdata_q, ram_wdata_d;
    logic [3:0]             ram_be_q, ram_be_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [CW-1:0]          frame_len_q, frame_len_d;
    logic [15:0]            bad_count_q, bad_count_d;
    logic [15:0]            drop_count_q, drop_count_d;

    logic [CW-1:0]          byte_idx_s;
    logic [1:0]             lane_s;
    logic [ADDR_WIDTH-1:0]  word_s;
    logic [31:0]            base_data_s;
    logic [3:0]             base_be_s;
    logic [31:0]            merged_data_s;
    logic [3:0]             merged_be_s;
    logic                   oversize_s;

    // Byte position decode and lane merge for the byte currently on the bus
    always_comb begin
        // A frame always starts from an empty accumulator at byte 0
        if (state_q == ST_IDLE) begin
            byte_idx_s  = '0;
            base_data_s = 32'h0000_0000;
            base_be_s   = 4'b0000;
        end else begin
            byte_idx_s  = cnt_q;
            base_data_s = acc_q;
            base_be_s   = acc_be_q;
        end
        lane_s        = byte_idx_s[1:0];
        word_s        = byte_idx_s[ADDR_WIDTH+1:2];
        merged_data_s = base_data_s;
        merged_data_s[{lane_s, 3'b000} +: 8] = rx.rx_axis_tdata;
        merged_be_s   = base_be_s | (4'b0001 << lane_s);
        oversize_s    = (byte_idx_s >= CW'(MAX_BYTES));
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        acc_be_d      = acc_be_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_be_d      = ram_be_q;
        frame_valid_d = frame_valid_q;
        frame_len_d   = frame_len_q;
        bad_count_d   = bad_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            ST_IDLE, ST_RECV: begin
                if (rx.rx_axis_tvalid) begin
                    if (oversize_s) begin
                        // Flush the lanes already gathered for the current word,
                        // but never write the offending byte itself.
                        if (acc_be_q != 4'b0000) begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = word_s;
                            ram_wdata_d = acc_q;
                            ram_be_d    = acc_be_q;
                        end else begin
                            ram_we_d    = 1'b0;
                        end
                        acc_d        = 32'h0000_0000;
                        acc_be_d     = 4'b0000;
                        cnt_d        = '0;
                        drop_count_d = sat_inc(drop_count_q);
                        state_d      = rx.rx_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        cnt_d    = byte_idx_s + CW'(1);
                        acc_d    = merged_data_s;
                        acc_be_d = merged_be_s;
                        state_d  = ST_RECV;
                        if ((lane_s == 2'd3) || rx.rx_axis_tlast) begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = word_s;
                            ram_wdata_d = merged_data_s;
                            ram_be_d    = merged_be_s;
                            acc_d       = 32'h0000_0000;
                            acc_be_d    = 4'b0000;
                        end else begin
                            ram_we_d    = 1'b0;
                        end
                        if (rx.rx_axis_tlast) begin
                            cnt_d = '0;
                            if (rx.rx_axis_tuser) begin
                                bad_count_d = sat_inc(bad_count_q);
                                state_d     = ST_IDLE;
                            end else begin
                                frame_valid_d = 1'b1;
                                frame_len_d   = byte_idx_s + CW'(1);
                                state_d       = ST_HOLD;
                            end
                        end else begin
                            cnt_d = byte_idx_s + CW'(1);
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DROP: begin
                // A held buffer can still be released while a frame is dropped
                if (frame_ack && frame_valid_q) begin
                    frame_valid_d = 1'b0;
                end else begin
                    frame_valid_d = frame_valid_q;
                end
                if (rx.rx_axis_tvalid && rx.rx_axis_tlast) begin
                    state_d = (frame_valid_q && !frame_ack) ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (rx.rx_axis_tvalid) begin
                    drop_count_d = sat_inc(drop_count_q);
                    if (frame_ack) begin
                        frame_valid_d = 1'b0;
                    end else begin
                        frame_valid_d = 1'b1;
                    end
                    if (!rx.rx_axis_tlast) begin
                        state_d = ST_DROP;
                    end else if (frame_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            acc_q         <= 32'h0000_0000;
            acc_be_q      <= 4'b0000;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= 32'h0000_0000;
            ram_be_q      <= 4'b0000;
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            bad_count_q   <= 16'h0000;
            drop_count_q  <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            acc_be_q      <= acc_be_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_be_q      <= ram_be_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            bad_count_q   <= bad_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_be      = ram_be_q;
    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign bad_count   = bad_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_rx_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_packer
// Drives directed and random frames into rx_frame_packer and compares every
// RAM write, the posted frame status and the counters against a frame-level
// reference model built from byte lists and word arithmetic.
// ---------------------------------------------------------------------------
module tb_rx_frame_packer;
    localparam int AW   = 9;
    localparam int MAXB = 1522;
    localparam int CW   = AW + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [3:0]      ram_be;
    logic            frame_valid;
    logic [CW-1:0]   frame_len;
    logic            frame_ack;
    logic [15:0]     bad_count;
    logic [15:0]     drop_count;

    rx_frame_packer_if rxif ();

    rx_frame_packer #(.ADDR_WIDTH(AW), .MAX_BYTES(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rxif),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_be      (ram_be),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_ack   (frame_ack),
        .bad_count   (bad_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        int          be;
        logic [31:0] data;
        logic        fv;
        int          cyc;
    } wr_t;

    wr_t wq[$];

    // Capture every RAM write with the frame_valid seen alongside it
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_t w;
            w.addr = int'(ram_addr);
            w.be   = int'(ram_be);
            w.data = ram_wdata;
            w.fv   = frame_valid;
            w.cyc  = cyc;
            wq.push_back(w);
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_held = 1'b0;
    int m_len  = 0;
    int m_bad  = 0;
    int m_drop = 0;

    logic [7:0] tx   [0:2047];
    int         bcyc [0:2047];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int len, input bit tu, input int gap, input int ack_at, input bit rnd);
        wq.delete();
        for (int i = 0; i < len; i++) begin
            tx[i] = rnd ? 8'($urandom) : i[7:0];
        end
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rxif.rx_axis_tvalid = 1'b1;
            rxif.rx_axis_tdata  = tx[i];
            rxif.rx_axis_tlast  = (i == len - 1);
            rxif.rx_axis_tuser  = (i == len - 1) ? tu : 1'b0;
            frame_ack           = (i == ack_at);
            bcyc[i]             = cyc;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                rxif.rx_axis_tvalid = 1'b0;
                rxif.rx_axis_tdata  = 8'($urandom);
                rxif.rx_axis_tlast  = 1'($urandom);
                rxif.rx_axis_tuser  = 1'($urandom);
                frame_ack           = 1'b0;
            end
        end
        @(posedge clk); #1;
        rxif.rx_axis_tvalid = 1'b0;
        rxif.rx_axis_tlast  = 1'b0;
        rxif.rx_axis_tuser  = 1'b0;
        frame_ack           = 1'b0;
    endtask

    task automatic check_frame(input int len, input bit tu, input int ack_at, input string tag);
        wr_t exp[$];
        if (m_held) begin
            m_drop++;
            if (ack_at >= 0 && ack_at < len) m_held = 1'b0;
        end else begin
            int n;
            int nw;
            n  = (len > MAXB) ? MAXB : len;
            nw = (n + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                wr_t w;
                int  trig;
                w.addr = k;
                w.be   = 0;
                w.data = 32'h0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * k + j < n) begin
                        w.be = w.be | (1 << j);
                        w.data[8*j +: 8] = tx[4*k+j];
                    end
                end
                if (4 * k + 3 < n) trig = 4 * k + 3;
                else trig = (len > MAXB) ? MAXB : n - 1;
                w.cyc = bcyc[trig] + 1;
                w.fv  = (k == nw - 1) && (len <= MAXB) && !tu;
                exp.push_back(w);
            end
            if (len > MAXB) m_drop++;
            else if (tu) m_bad++;
            else begin
                m_held = 1'b1;
                m_len  = len;
            end
        end
        repeat (2) @(negedge clk);
        chk({tag, " nwr"}, wq.size(), exp.size());
        for (int k = 0; k < exp.size() && k < wq.size(); k++) begin
            chk($sformatf("%s w%0d addr", tag, k), wq[k].addr, exp[k].addr);
            chk($sformatf("%s w%0d be", tag, k), wq[k].be, exp[k].be);
            chk($sformatf("%s w%0d data", tag, k), wq[k].data, exp[k].data);
            chk($sformatf("%s w%0d fv", tag, k), wq[k].fv, exp[k].fv);
            chk($sformatf("%s w%0d cyc", tag, k), wq[k].cyc, exp[k].cyc);
        end
        chk({tag, " frame_valid"}, frame_valid, m_held);
        chk({tag, " frame_len"}, frame_len, m_len);
        chk({tag, " bad_count"}, bad_count, m_bad);
        chk({tag, " drop_count"}, drop_count, m_drop);
    endtask

    task automatic release_buf(input string tag);
        @(posedge clk); #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        m_held = 1'b0;
        @(negedge clk);
        chk({tag, " ack frame_valid"}, frame_valid, 1'b0);
        chk({tag, " ack frame_len"}, frame_len, m_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ram_we"}, ram_we, 1'b0);
        chk({tag, " ram_addr"}, ram_addr, 0);
        chk({tag, " ram_wdata"}, ram_wdata, 32'h0);
        chk({tag, " ram_be"}, ram_be, 4'h0);
        chk({tag, " frame_valid"}, frame_valid, 1'b0);
        chk({tag, " frame_len"}, frame_len, 0);
        chk({tag, " bad_count"}, bad_count, 16'h0);
        chk({tag, " drop_count"}, drop_count, 16'h0);
    endtask

    initial begin
        int len;
        bit tu;
        int gap;
        int ack_at;

        rst = 1'b1;
        frame_ack = 1'b0;
        rxif.rx_axis_tvalid = 1'b0;
        rxif.rx_axis_tdata  = 8'h00;
        rxif.rx_axis_tlast  = 1'b0;
        rxif.rx_axis_tuser  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // 64-byte contiguous good frame
        send(64, 1'b0, 0, -1, 1'b0);
        check_frame(64, 1'b0, -1, "f64");
        if (wq.size() > 0) chk("f64 word0", wq[0].data, 32'h03020100);
        release_buf("f64");

        // 65-byte good frame with 2-cycle gaps
        send(65, 1'b0, 2, -1, 1'b1);
        check_frame(65, 1'b0, -1, "f65gap");
        if (wq.size() == 17) chk("f65gap last be", wq[16].be, 4'b0001);
        release_buf("f65gap");

        // 60-byte bad frame
        send(60, 1'b1, 0, -1, 1'b1);
        check_frame(60, 1'b1, -1, "bad60");

        // 1600-byte oversize frame, then a good one
        send(1600, 1'b0, 0, -1, 1'b1);
        check_frame(1600, 1'b0, -1, "over1600");
        if (wq.size() > 0) chk("over1600 last addr", wq[wq.size()-1].addr, 380);
        send(100, 1'b0, 0, -1, 1'b1);
        check_frame(100, 1'b0, -1, "after_over");
        release_buf("after_over");

        // Frame arriving while buffer held, single-byte one too, then ack
        send(40, 1'b0, 0, -1, 1'b1);
        check_frame(40, 1'b0, -1, "held1");
        send(50, 1'b0, 1, -1, 1'b1);
        check_frame(50, 1'b0, -1, "busy2");
        send(1, 1'b0, 0, -1, 1'b1);
        check_frame(1, 1'b0, -1, "busy1b");
        release_buf("held1");
        send(33, 1'b0, 0, -1, 1'b1);
        check_frame(33, 1'b0, -1, "third");

        // Ack together with the first byte of a frame in HOLD
        send(20, 1'b0, 0, 0, 1'b1);
        check_frame(20, 1'b0, 0, "ack_first");
        // Held again by a fresh frame, then ack while dropping another
        send(7, 1'b0, 0, -1, 1'b1);
        check_frame(7, 1'b0, -1, "hold_again");
        send(30, 1'b0, 0, 12, 1'b1);
        check_frame(30, 1'b0, 12, "ack_in_drop");
        // Ack outside HOLD is ignored
        release_buf("idle_ack");
        send(1, 1'b0, 0, 0, 1'b1);
        check_frame(1, 1'b0, 0, "one_byte");
        release_buf("one_byte");

        // Random frames
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 7) == 0) len = $urandom_range(MAXB - 3, MAXB + 3);
            else len = $urandom_range(1, 48);
            tu     = ($urandom_range(0, 3) == 0);
            gap    = $urandom_range(0, 2);
            ack_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            send(len, tu, gap, ack_at, 1'b1);
            check_frame(len, tu, ack_at, $sformatf("rnd%0d", r));
            if ($urandom_range(0, 1) == 1) release_buf($sformatf("rnd%0d", r));
        end
        if (m_held) release_buf("pre_rst");

        // Reset in the middle of a frame
        wq.delete();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rxif.rx_axis_tvalid = 1'b1;
            rxif.rx_axis_tdata  = 8'($urandom);
            rxif.rx_axis_tlast  = 1'b0;
            rxif.rx_axis_tuser  = 1'b0;
        end
        @(posedge clk); #1;
        rxif.rx_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        #1 rst = 1'b0;
        m_held = 1'b0;
        m_len  = 0;
        m_bad  = 0;
        m_drop = 0;
        send(64, 1'b0, 0, -1, 1'b0);
        check_frame(64, 1'b0, -1, "post_rst");
        if (wq.size() > 0) chk("post_rst addr0", wq[0].addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
